// File: rtl/counter_arbiter.sv
// Shared up-counter arbitrated round-robin among NREQ requesters.
// The winner's run length is latched at grant; the counter clears, then
// counts up to that length, and the owner receives a single-cycle done pulse.
// An owner releasing its request mid-run aborts without a done pulse.
module counter_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*CW-1:0] len,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [CW-1:0]     count,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [IW-1:0]   ptr, ptr_next;
  logic [IW-1:0]   owner, owner_next;
  logic [CW-1:0]   target, target_next;
  logic [CW-1:0]   count_next, count_inc;
  logic [NREQ-1:0] grant_next, done_next;
  logic            busy_next;
  logic            owner_req;

  logic [CW-1:0]   len_arr [NREQ];
  logic            found;
  logic [IW-1:0]   win;
  logic [CW-1:0]   win_len;
  int unsigned     cand;
  logic [IW-1:0]   cand_idx;

  for (genvar g = 0; g < NREQ; g++) begin : g_len
    assign len_arr[g] = len[g*CW +: CW];
  end

  assign owner_req = req[owner];
  assign count_inc = count + CW'(1);

  // Round-robin search: first requester at or after ptr+1, wrapping.
  always_comb begin
    found    = 1'b0;
    win      = ptr;
    win_len  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand     = (32'(ptr) + i) % NREQ;
      cand_idx = IW'(cand);
      if (!found && req[cand_idx]) begin
        found   = 1'b1;
        win     = cand_idx;
        win_len = len_arr[cand_idx];
      end
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_next  = state;
    ptr_next    = ptr;
    owner_next  = owner;
    target_next = target;
    count_next  = count;
    grant_next  = grant;
    done_next   = '0;
    unique case (state)
      IDLE: begin
        grant_next = '0;
        if (found) begin
          state_next       = CLEAR;
          owner_next       = win;
          target_next      = win_len;
          grant_next[win]  = 1'b1;
        end
      end
      CLEAR: begin
        if (!owner_req) begin
          state_next = IDLE;
          grant_next = '0;
          ptr_next   = owner;
        end else begin
          count_next = '0;
          if (target == '0) begin
            state_next = DONE;
            done_next  = grant;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (!owner_req) begin
          state_next = IDLE;
          grant_next = '0;
          ptr_next   = owner;
        end else begin
          count_next = count_inc;
          if (count_inc == target) begin
            state_next = DONE;
            done_next  = grant;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        grant_next = '0;
        ptr_next   = owner;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  // State and registered outputs; reset overrides every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= IW'(NREQ - 1);
      owner  <= '0;
      target <= '0;
      count  <= '0;
      grant  <= '0;
      done   <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_next;
      ptr    <= ptr_next;
      owner  <= owner_next;
      target <= target_next;
      count  <= count_next;
      grant  <= grant_next;
      done   <= done_next;
      busy   <= busy_next;
    end
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: directed vector table, hand-written corner
// sequences, and randomized traffic checked against a cycle-count model.
module tb_counter_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*CW-1:0] len;
  logic [NREQ-1:0]   grant, done;
  logic [CW-1:0]     count;
  logic              busy;

  int passed = 0;
  int total  = 0;

  counter_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .clk(clk), .reset(reset), .req(req), .len(len),
    .grant(grant), .done(done), .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: an active run is described by cycles elapsed since its grant (k).
  // k=1 grant edge, k=2+j shows count=j, done when k==2+L, released next.
  int              m_owner, m_k, m_L, m_ptr, m_count;
  logic [NREQ-1:0] m_grant, m_done;

  task automatic model_edge();
    m_done = '0;
    if (reset) begin
      m_owner = -1; m_ptr = NREQ - 1; m_count = 0; m_grant = '0; m_k = 0; m_L = 0;
    end else if (m_owner < 0) begin
      m_grant = '0;
      for (int j = 1; j <= NREQ; j++) begin
        int c = (m_ptr + j) % NREQ;
        if (m_owner < 0 && ((req >> c) & NREQ'(1)) != '0) begin
          m_owner = c;
          m_L     = int'(CW'(len >> (c * CW)));
          m_k     = 1;
          m_grant = NREQ'(1) << c;
        end
      end
    end else if (m_k == m_L + 2) begin
      m_ptr = m_owner; m_owner = -1; m_grant = '0;
    end else if (((req >> m_owner) & NREQ'(1)) == '0) begin
      m_ptr = m_owner; m_owner = -1; m_grant = '0;
    end else begin
      m_k++;
      m_count = m_k - 2;
      if (m_k == m_L + 2) m_done = m_grant;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_model(input string name);
    check(name, {19'd0, grant, done, count, busy},
          {19'd0, m_grant, m_done, CW'(m_count), (m_owner >= 0)});
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  rq;
    logic [15:0] ln;
    logic [3:0]  g;
    logic [3:0]  d;
    logic [3:0]  c;
    logic        b;
  } vec_t;

  vec_t tbl[10];

  initial begin
    reset = 1'b1;
    req   = '0;
    len   = '0;

    // Single run of length 3, then a zero-length run.
    tbl[0] = '{1'b1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'd0, 1'b0};
    tbl[1] = '{1'b0, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 4'd0, 1'b1};
    tbl[2] = '{1'b0, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 4'd0, 1'b1};
    tbl[3] = '{1'b0, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 4'd1, 1'b1};
    tbl[4] = '{1'b0, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 4'd2, 1'b1};
    tbl[5] = '{1'b0, 4'b0001, 16'h0003, 4'b0001, 4'b0001, 4'd3, 1'b1};
    tbl[6] = '{1'b0, 4'b0000, 16'h0003, 4'b0000, 4'b0000, 4'd3, 1'b0};
    tbl[7] = '{1'b0, 4'b0100, 16'h0000, 4'b0100, 4'b0000, 4'd3, 1'b1};
    tbl[8] = '{1'b0, 4'b0100, 16'h0000, 4'b0100, 4'b0100, 4'd0, 1'b1};
    tbl[9] = '{1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'd0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      reset = tbl[i].rst;
      req   = tbl[i].rq;
      len   = tbl[i].ln;
      step();
      check($sformatf("vec%0d", i), {19'd0, grant, done, count, busy},
            {19'd0, tbl[i].g, tbl[i].d, tbl[i].c, tbl[i].b});
    end

    // Abort mid-run: count holds, no done, pointer moves past the owner.
    req = 4'b0010; len = 16'h00F0;
    step();
    check("abort_grant", {28'd0, grant}, 32'h2);
    for (int i = 0; i < 20; i++) begin
      step();
      if (count == 4'd5) break;
    end
    check("abort_reach5", {28'd0, count}, 32'd5);
    req = 4'b0000;
    step();
    check("abort_state", {19'd0, grant, done, count, busy}, {19'd0, 4'b0000, 4'b0000, 4'd5, 1'b0});
    req = 4'b0011;
    step();
    check("abort_next_rr", {28'd0, grant}, 32'h1);
    req = 4'b0000;
    step();
    check("abort_in_clear", {19'd0, grant, done, count, busy}, {19'd0, 4'b0000, 4'b0000, 4'd5, 1'b0});

    // Reset in the middle of a run.
    req = 4'b0001; len = 16'h000A;
    step();
    for (int i = 0; i < 20; i++) begin
      step();
      if (count == 4'd7) break;
    end
    check("rst_reach7", {28'd0, count}, 32'd7);
    reset = 1'b1;
    step();
    check("rst_midrun", {19'd0, grant, done, count, busy}, 32'd0);
    reset = 1'b0; req = 4'b1001;
    step();
    check("rst_then_req0", {28'd0, grant}, 32'h1);
    req = 4'b0000;
    step();
    req = 4'b1000;
    step();
    check("rst_then_req3", {28'd0, grant}, 32'h8);
    req = 4'b0000;
    step();

    // All requesters held, length 1: strict rotation starting at 0.
    begin
      logic [19:0]     order;
      logic [NREQ-1:0] prev;
      int              got;
      order = 20'h18421;
      prev  = '0;
      got   = 0;
      reset = 1'b1;
      step();
      reset = 1'b0; req = 4'b1111; len = 16'h1111;
      for (int i = 0; i < 40; i++) begin
        step();
        check_model("rr_cycle");
        if (grant != '0 && prev == '0 && got < 5) begin
          check($sformatf("rr_order%0d", got), {28'd0, grant}, {28'd0, 4'(order >> (4 * got))});
          got++;
        end
        prev = grant;
      end
      check("rr_grants_seen", got, 5);
    end

    // Randomized traffic against the model.
    reset = 1'b1; req = '0;
    step();
    reset = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < NREQ; b++)
        if ($urandom_range(0, 7) == 0) req = req ^ (NREQ'(1) << b);
      if ($urandom_range(0, 3) == 0) len = 16'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      step();
      check_model("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
